buffet_fill_agent: RTL

//  Credit-driven fill engine directly upstream of a buffet. Streams a strided block of elements from

---
 rtl/buffet_fill_agent.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/buffet_fill_agent.sv
// buffet_fill_agent
//   Credit-driven fill engine upstream of a buffet. Streams a strided block of
//   elements from backing memory into the buffet fill port. A memory read is
//   issued only while a buffet credit is held; credits returned by the buffet
//   replenish the free-slot count. One job runs per start_i pulse.
//
// Ports
//   clk, reset_i                      clock, synchronous active-high reset
//   start_i, cfg_base_i,
//   cfg_stride_i, cfg_len_i           job launch (sampled in IDLE only)
//   busy_o, done_o                    job in progress / one-cycle completion pulse
//   credit_in, credit_valid_i,
//   credit_ready_o                    freed-slot return from the buffet
//   mem_req_addr_o, mem_req_valid_o,
//   mem_req_ready_i                   read request channel
//   mem_resp_data_i, mem_resp_valid_i,
//   mem_resp_ready_o                  in-order read response channel
//   push_data_o, push_data_valid_o,
//   push_data_ready_i                 buffet fill channel
//
// Optional build macro FILL_AGENT_PERF_EN adds:
//   stall_cnt_o   RUN cycles stalled on zero credits (cleared on accepted start)
//   credit_err_o  sticky flag, credit count had to be clamped at BUF_DEPTH
module buffet_fill_agent #(
  parameter int unsigned IDX_WIDTH       = 8,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned BUF_DEPTH       = 16,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] cfg_base_i,
  input  logic [ADDR_WIDTH-1:0] cfg_stride_i,
  input  logic [IDX_WIDTH-1:0]  cfg_len_i,
  output logic                  busy_o,
  output logic                  done_o,
  input  logic [IDX_WIDTH-1:0]  credit_in,
  input  logic                  credit_valid_i,
  output logic                  credit_ready_o,
  output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  input  logic [DATA_WIDTH-1:0] mem_resp_data_i,
  input  logic                  mem_resp_valid_i,
  output logic                  mem_resp_ready_o,
  output logic [DATA_WIDTH-1:0] push_data_o,
  output logic                  push_data_valid_o,
  input  logic                  push_data_ready_i
`ifdef FILL_AGENT_PERF_EN
  ,
  output logic [31:0]           stall_cnt_o,
  output logic                  credit_err_o
`endif
);

  localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = IDX_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state;
  state_t                state_next;

  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] stride;
  logic [IDX_WIDTH-1:0]  len;
  logic [IDX_WIDTH-1:0]  issued;
  logic [IDX_WIDTH-1:0]  pushed;
  logic [IDX_WIDTH-1:0]  credits;
  logic [CNT_W-1:0]      outstanding;
  logic [CNT_W-1:0]      awaiting;
  logic                  req_valid;

  logic [DATA_WIDTH-1:0] fifo_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      fifo_count;

  logic                  start_accept;
  logic                  req_fire;
  logic                  push_fire;
  logic                  credit_fire;
  logic                  resp_accept;

  logic [SUM_W-1:0]      credit_sum;
  logic                  clamp;
  logic [IDX_WIDTH-1:0]  credits_n;
  logic [IDX_WIDTH-1:0]  issued_n;
  logic [IDX_WIDTH-1:0]  len_n;
  logic [CNT_W-1:0]      outstanding_n;
  logic                  req_valid_n;

  assign start_accept      = (state == IDLE) && start_i;
  assign req_fire          = req_valid && mem_req_ready_i;
  assign push_fire         = push_data_valid_o && push_data_ready_i;
  assign credit_ready_o    = !reset_i;
  assign credit_fire       = credit_valid_i && credit_ready_o;
  // Responses are only taken into the FIFO while a request of the current
  // job is still unanswered; stale data from before a reset is discarded.
  assign resp_accept       = mem_resp_valid_i && (awaiting != '0);

  assign mem_resp_ready_o  = 1'b1;
  assign mem_req_valid_o   = req_valid;
  assign mem_req_addr_o    = addr;
  assign push_data_valid_o = (fifo_count != '0);
  assign push_data_o       = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          state_next = (cfg_len_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        busy_o = 1'b1;
        if (issued == len) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        busy_o = 1'b1;
        if ((pushed == len) && (fifo_count == '0)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done_o     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The request valid is registered, so it is derived from next-cycle counts.
  // While a request is stalled on mem_req_ready_i the inputs to this term can
  // only move in its favour, which keeps valid and address stable.
  always_comb begin
    credit_sum    = {1'b0, credits}
                  + (credit_fire ? {1'b0, credit_in} : '0)
                  - SUM_W'(req_fire);
    clamp         = (credit_sum > SUM_W'(BUF_DEPTH));
    credits_n     = clamp ? IDX_WIDTH'(BUF_DEPTH) : credit_sum[IDX_WIDTH-1:0];
    issued_n      = start_accept ? '0 : issued + IDX_WIDTH'(req_fire);
    len_n         = start_accept ? cfg_len_i : len;
    outstanding_n = outstanding + CNT_W'(req_fire) - CNT_W'(push_fire);
    req_valid_n   = (state_next == RUN)
                 && (credits_n != '0)
                 && (outstanding_n < CNT_W'(MAX_OUTSTANDING))
                 && (issued_n < len_n);
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      credits     <= IDX_WIDTH'(BUF_DEPTH);
      issued      <= '0;
      pushed      <= '0;
      len         <= '0;
      outstanding <= '0;
      awaiting    <= '0;
      req_valid   <= 1'b0;
      addr        <= '0;
      stride      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
    end else begin
      credits     <= credits_n;
      issued      <= issued_n;
      len         <= len_n;
      outstanding <= outstanding_n;
      req_valid   <= req_valid_n;
      awaiting    <= awaiting + CNT_W'(req_fire) - CNT_W'(resp_accept);
      if (start_accept) begin
        addr   <= cfg_base_i;
        stride <= cfg_stride_i;
        pushed <= '0;
      end else begin
        if (req_fire) begin
          addr <= addr + stride;
        end
        if (push_fire) begin
          pushed <= pushed + IDX_WIDTH'(1);
        end
      end
      if (resp_accept) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (push_fire) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      fifo_count <= fifo_count + CNT_W'(resp_accept) - CNT_W'(push_fire);
    end
  end

  always_ff @(posedge clk) begin
    if (resp_accept) begin
      fifo_mem[wr_ptr] <= mem_resp_data_i;
    end
  end

`ifdef FILL_AGENT_PERF_EN
  always_ff @(posedge clk) begin
    if (reset_i) begin
      stall_cnt_o  <= '0;
      credit_err_o <= 1'b0;
    end else begin
      if (start_accept) begin
        stall_cnt_o <= '0;
      end else if ((state == RUN) && (issued < len) && (credits == '0)) begin
        stall_cnt_o <= stall_cnt_o + 32'd1;
      end
      if (clamp) begin
        credit_err_o <= 1'b1;
      end
    end
  end
`endif

endmodule
